// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-channel round-robin arbiter onto a single memory port
module mem_port_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_oe,
  input  logic [1:0]          req_we,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  input  logic [2*SIZE_W-1:0] req_size,
  output logic [2*DATA_W-1:0] req_rdata,
  output logic [1:0]          req_rdy,
  output logic                mem_oe,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [SIZE_W-1:0]   mem_size,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rdy,
  output logic                grant_id,
  output logic                busy,
  output logic                err_proto,
  output logic                err_timeout
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, ACK = 2'd2} state_t;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [1:0] elig;
  logic       pick;
  logic       prio_ptr;
  logic       done_ok;
  logic       done_to;
  logic [7:0] wait_cnt;

  // A channel asserting both strobes is a protocol violation and never competes.
  assign elig    = req_oe ^ req_we;
  assign done_ok = (state == ISSUE) && mem_rdy;
  assign done_to = (state == ISSUE) && !mem_rdy && (wait_cnt == CNT_LAST);

  always_comb begin
    pick = 1'b0;
    if (elig == 2'b11)      pick = prio_ptr;
    else if (elig == 2'b10) pick = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (elig != 2'b00) state_nxt = ISSUE;
      ISSUE:   if (done_ok || done_to) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_ptr    <= 1'b0;
      wait_cnt    <= '0;
      mem_oe      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_size    <= '0;
      req_rdy     <= 2'b00;
      req_rdata   <= '0;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
      err_proto   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      req_rdy <= 2'b00;
      case (state)
        IDLE: begin
          if ((req_oe & req_we) != 2'b00) err_proto <= 1'b1;
          if (elig != 2'b00) begin
            grant_id  <= pick;
            mem_oe    <= req_oe[pick];
            mem_we    <= req_we[pick];
            mem_addr  <= pick ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
            mem_wdata <= pick ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            mem_size  <= pick ? req_size[2*SIZE_W-1:SIZE_W]   : req_size[SIZE_W-1:0];
            wait_cnt  <= '0;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (done_ok || done_to) begin
            mem_oe            <= 1'b0;
            mem_we            <= 1'b0;
            req_rdy[grant_id] <= 1'b1;
            if (done_to) err_timeout <= 1'b1;
            // mem_oe still holds the latched direction of the access being retired.
            if (done_to || mem_oe) begin
              if (grant_id) req_rdata[2*DATA_W-1:DATA_W] <= done_to ? '0 : mem_rdata;
              else          req_rdata[DATA_W-1:0]        <= done_to ? '0 : mem_rdata;
            end
          end
        end
        ACK: begin
          prio_ptr <= ~grant_id;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int TMO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_oe, req_we, req_rdy;
  logic [13:0] req_addr;
  logic [15:0] req_wdata, req_rdata;
  logic [7:0]  req_size;
  logic        mem_oe, mem_we;
  logic [6:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [3:0]  mem_size;
  logic        mem_rdy, grant_id, busy, err_proto, err_timeout;

  int total = 0;
  int bad   = 0;

  logic [1:0] c_oe, c_we;
  logic [6:0] c_addr [2];
  logic [7:0] c_wd   [2];
  logic [3:0] c_sz   [2];
  logic [7:0] exp_rd [2];
  int         exp_prio;
  logic       exp_ep, exp_to;
  int         g;

  mem_port_arbiter #(.ADDR_W(7), .DATA_W(8), .SIZE_W(4), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_size(req_size), .req_rdata(req_rdata), .req_rdy(req_rdy),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .grant_id(grant_id), .busy(busy), .err_proto(err_proto), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply;
    req_oe    = c_oe;
    req_we    = c_we;
    req_addr  = {c_addr[1], c_addr[0]};
    req_wdata = {c_wd[1], c_wd[0]};
    req_size  = {c_sz[1], c_sz[0]};
  endtask

  task automatic set_ch(input int c, input logic oe, input logic we,
                        input logic [6:0] a, input logic [7:0] d, input logic [3:0] s);
    c_oe[c] = oe; c_we[c] = we; c_addr[c] = a; c_wd[c] = d; c_sz[c] = s;
  endtask

  // mode 1: always a legal read or write; mode 2: idle, read, write or illegal both
  task automatic rand_ch(input int c, input int mode);
    int r;
    r = (mode == 1) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 3));
    set_ch(c, r[0], r[1], 7'($urandom), 8'($urandom), 4'($urandom));
  endtask

  // Called in an IDLE cycle with at least one eligible request applied; returns in the
  // following IDLE cycle, before that cycle's sampling edge.
  task automatic serve(input int dly, input logic [7:0] rd, input int mode, output int ch);
    int         nstb, exp_n;
    logic       e0, e1, ok;
    logic [20:0] exp_bus;
    e0 = c_oe[0] ^ c_we[0];
    e1 = c_oe[1] ^ c_we[1];
    if (e0 && e1)  ch = exp_prio;
    else if (e1)   ch = 1;
    else           ch = 0;
    ok    = (dly >= 1) && (dly <= TMO);
    exp_n = ok ? dly : TMO;
    if ((c_oe & c_we) != 2'b00) exp_ep = 1'b1;
    exp_bus = {c_oe[ch], c_we[ch], c_addr[ch], c_wd[ch], c_sz[ch]};
    mem_rdy   = 1'($urandom);
    mem_rdata = 8'($urandom);
    tick;
    mem_rdy = 1'b0;
    chk("grant_id", 32'(grant_id), 32'(ch));
    chk("busy_issue", 32'(busy), 32'd1);
    chk("err_proto", 32'(err_proto), 32'(exp_ep));
    chk("rdy_issue", 32'(req_rdy), 32'd0);
    nstb = 0;
    while ((mem_oe || mem_we) && nstb < 300) begin
      nstb++;
      chk("mem_bus", 32'({mem_oe, mem_we, mem_addr, mem_wdata, mem_size}), 32'(exp_bus));
      if (nstb == dly) begin
        mem_rdy = 1'b1; mem_rdata = rd;
      end else begin
        mem_rdy = 1'b0; mem_rdata = 8'($urandom);
      end
      tick;
    end
    chk("strobe_cycles", 32'(nstb), 32'(exp_n));
    if (!ok) begin
      exp_rd[ch] = 8'h00;
      exp_to     = 1'b1;
    end else if (c_oe[ch]) begin
      exp_rd[ch] = rd;
    end
    chk("req_rdy", 32'(req_rdy), ch ? 32'd2 : 32'd1);
    chk("rdata", 32'(req_rdata), 32'({exp_rd[1], exp_rd[0]}));
    chk("strobe_ack", 32'({mem_oe, mem_we}), 32'd0);
    chk("err_timeout", 32'(err_timeout), 32'(exp_to));
    exp_prio  = 1 - ch;
    mem_rdy   = 1'($urandom);
    mem_rdata = 8'($urandom);
    if (mode == 0) set_ch(ch, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    else           rand_ch(ch, mode);
    if (mode == 2 && (c_oe[1-ch] == c_we[1-ch])) rand_ch(1 - ch, 2);
    apply;
    tick;
    mem_rdy = 1'b0;
    chk("rdy_idle", 32'(req_rdy), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    mem_rdy = 1'b1;
    mem_rdata = 8'h5A;
    set_ch(0, 1'b1, 1'b1, 7'h11, 8'h22, 4'h3);
    set_ch(1, 1'b1, 1'b0, 7'h44, 8'h55, 4'h6);
    apply;
    exp_prio = 0; exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; exp_ep = 1'b0; exp_to = 1'b0;
    tick; tick;
    chk("rst_ctrl", 32'({req_rdy, mem_oe, mem_we, grant_id, busy, err_proto, err_timeout}), 32'd0);
    chk("rst_bus", 32'({mem_addr, mem_wdata, mem_size}), 32'd0);
    chk("rst_rdata", 32'(req_rdata), 32'd0);
    set_ch(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    set_ch(1, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    apply;
    reset = 1'b0;
    mem_rdy = 1'b0;
    tick;
    chk("idle_after_rst", 32'({busy, mem_oe, mem_we}), 32'd0);

    // simultaneous requests right after reset: channel 0 wins first
    set_ch(0, 1'b0, 1'b1, 7'h01, 8'h3C, 4'h1);
    set_ch(1, 1'b1, 1'b0, 7'h02, 8'h00, 4'h2);
    apply;
    serve(1, 8'h00, 0, g);
    chk("first_grant", 32'(g), 32'd0);
    serve(1, 8'h77, 0, g);
    chk("second_grant", 32'(g), 32'd1);

    // continuous contention alternates grants
    rand_ch(0, 1); rand_ch(1, 1); apply;
    for (int i = 0; i < 6; i++) begin
      serve(int'($urandom_range(1, TMO)), 8'($urandom), 1, g);
      chk("alt_grant", 32'(g), 32'(i % 2));
    end
    set_ch(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    set_ch(1, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    apply;

    // single read with 2-cycle memory delay
    set_ch(0, 1'b1, 1'b0, 7'h05, 8'h00, 4'h1);
    apply;
    serve(2, 8'hA5, 0, g);
    chk("read_grant", 32'(g), 32'd0);
    chk("read_a5", 32'(req_rdata[7:0]), 32'hA5);

    // timeout on channel 1
    set_ch(1, 1'b1, 1'b0, 7'h0A, 8'h00, 4'h2);
    apply;
    serve(0, 8'hFF, 0, g);
    chk("to_grant", 32'(g), 32'd1);
    chk("to_rdata", 32'(req_rdata[15:8]), 32'd0);
    tick; tick;
    chk("to_sticky", 32'(err_timeout), 32'd1);

    // protocol error on channel 0 while channel 1 writes
    set_ch(0, 1'b1, 1'b1, 7'h33, 8'h44, 4'h5);
    set_ch(1, 1'b0, 1'b1, 7'h66, 8'h99, 4'h7);
    apply;
    serve(int'($urandom_range(1, TMO)), 8'h00, 0, g);
    chk("proto_grant", 32'(g), 32'd1);
    tick;
    chk("proto_no_grant", 32'({busy, req_rdy}), 32'd0);
    set_ch(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    apply;
    tick;
    chk("proto_sticky", 32'({err_proto, err_timeout}), 32'd3);

    // randomized traffic
    rand_ch(0, 2); rand_ch(1, 2); apply;
    for (int i = 0; i < 120; i++) begin
      if ((c_oe ^ c_we) != 2'b00) begin
        serve(int'($urandom_range(0, TMO + 1)), 8'($urandom), 2, g);
      end else begin
        if ((c_oe & c_we) != 2'b00) exp_ep = 1'b1;
        mem_rdy = 1'($urandom);
        tick;
        mem_rdy = 1'b0;
        chk("idle_quiet", 32'({busy, mem_oe, mem_we, req_rdy}), 32'd0);
        chk("idle_proto", 32'(err_proto), 32'(exp_ep));
        rand_ch(0, 2); rand_ch(1, 2); apply;
      end
    end

    // reset in the middle of an access
    set_ch(0, 1'b1, 1'b0, 7'h12, 8'h00, 4'h3);
    set_ch(1, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    apply;
    mem_rdy = 1'b0;
    tick;
    chk("mid_issue", 32'(mem_oe), 32'd1);
    tick;
    reset = 1'b1;
    set_ch(0, 1'b0, 1'b0, 7'h00, 8'h00, 4'h0);
    apply;
    tick;
    chk("mid_rst_ctrl", 32'({mem_oe, mem_we, busy, req_rdy, err_proto, err_timeout, grant_id}), 32'd0);
    chk("mid_rst_rdata", 32'(req_rdata), 32'd0);
    reset = 1'b0;
    mem_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("late_rdy_ignored", 32'({req_rdy, mem_oe, mem_we, busy}), 32'd0);
    end
    mem_rdy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, sets the per-channel memory address width.
REQ-002 Parameter DATA_W, default 8, sets the per-channel data width.
REQ-003 Parameter SIZE_W, default 4, sets the per-channel access-size field width.
REQ-004 Parameter TIMEOUT, default 16, sets the maximum number of ISSUE cycles before the access is aborted; legal range is 2 to 255.
REQ-005 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-006 Port clock, input, 1 bit, is the system clock; all state changes on its rising edge.
REQ-007 Port reset, input, 1 bit, is the synchronous active-high reset.
REQ-008 Port req_oe, input, 2 bits, is the per-channel read request, held until that channel's req_rdy.
REQ-009 Port req_we, input, 2 bits, is the per-channel write request, held until that channel's req_rdy.
REQ-010 Port req_addr, input, 2*ADDR_W bits, is the channel addresses; channel c occupies [c*ADDR_W +: ADDR_W].
REQ-011 Port req_wdata, input, 2*DATA_W bits, is the channel write data, packed the same way.
REQ-012 Port req_size, input, 2*SIZE_W bits, is the channel access sizes, packed the same way.
REQ-013 Port req_rdata, output, 2*DATA_W bits, is the read data returned to the channels.
REQ-014 Port req_rdy, output, 2 bits, is a one-cycle completion pulse per channel.
REQ-015 Port mem_oe, output, 1 bit, is the downstream read strobe.
REQ-016 Port mem_we, output, 1 bit, is the downstream write strobe.
REQ-017 Port mem_addr, output, ADDR_W bits, is the downstream address.
REQ-018 Port mem_wdata, output, DATA_W bits, is the downstream write data.
REQ-019 Port mem_size, output, SIZE_W bits, is the downstream access size.
REQ-020 Port mem_rdata, input, DATA_W bits, is the downstream read data, valid while mem_rdy is high.
REQ-021 Port mem_rdy, input, 1 bit, is the downstream completion flag.
REQ-022 Port grant_id, output, 1 bit, identifies the channel currently owning the port.
REQ-023 Port busy, output, 1 bit, is high in any state other than IDLE.
REQ-024 Port err_proto, output, 1 bit, is a sticky flag indicating req_oe and req_we were both high on the same channel.
REQ-025 Port err_timeout, output, 1 bit, is a sticky flag indicating an access was aborted by timeout.

Function
REQ-026 The FSM SHALL have exactly three states: IDLE, ISSUE, ACK; all outputs SHALL be registered.
REQ-027 A channel c is eligible when exactly one of req_oe[c] and req_we[c] is high.
REQ-028 In IDLE, if any channel is eligible: grant it (a sole eligible channel wins; if both are eligible, channel prio_ptr wins), latch its addr/wdata/size/direction, and go to ISSUE.
REQ-029 Latency: the cycle after the request is sampled in IDLE, mem_oe or mem_we SHALL be high with the latched address, data and size, and grant_id SHALL equal the granted channel.
REQ-030 In ISSUE, the mem_* outputs SHALL stay constant, and the wait counter SHALL increment each cycle starting from 0.
REQ-031 In ISSUE with mem_rdy=1: go to ACK; on reads, capture mem_rdata into the granted channel's req_rdata slice; the other slice SHALL remain unchanged.
REQ-032 In ISSUE, if the counter reaches TIMEOUT-1 without mem_rdy: go to ACK, write 0 into the granted rdata slice, and set err_timeout.
REQ-033 In ACK: req_rdy[grant_id] SHALL be high for exactly one cycle; mem_oe and mem_we SHALL be low; prio_ptr <= ~grant_id; the next state is IDLE.
REQ-034 req_rdy of the non-granted channel SHALL never be high.
REQ-035 mem_oe and mem_we SHALL never be high together, and both SHALL be low outside ISSUE.
REQ-036 A channel with both req_oe and req_we high SHALL never be granted; in IDLE it sets err_proto, and the other channel remains serviceable.
REQ-037 Requests arriving during ISSUE or ACK SHALL be held by the requester and are arbitrated in the next IDLE.
REQ-038 Minimum service period: grant to next grant is 3 cycles when mem_rdy arrives in the first ISSUE cycle.
REQ-039 mem_rdy seen in IDLE or ACK SHALL be ignored.
REQ-040 Under continuous requests from both channels, grants SHALL alternate 0,1,0,1.

Reset
REQ-041 On reset=1 at a rising edge, the next state SHALL be IDLE, regardless of the current state.
REQ-042 On reset, these outputs and state SHALL be 0: prio_ptr, counter, mem_oe, mem_we, mem_addr, mem_wdata, mem_size, req_rdy, req_rdata, grant_id, busy, err_proto, err_timeout.
REQ-043 Reset during ISSUE SHALL abort the access without asserting req_rdy; a mem_rdy arriving afterwards SHALL be ignored.
REQ-044 Sticky error flags SHALL be cleared only by reset.

Verification
REQ-045 Single read: ch0 oe, addr 0x05; memory returns 0xA5 with a 2-cycle delay -> mem_oe high for 2 cycles at addr 0x05, then req_rdy[0] pulses once with req_rdata[7:0]=0xA5.
REQ-046 Simultaneous requests after reset: ch0 write 0x3C to addr 0x01, ch1 read addr 0x02 -> ch0 served first, ch1 second, grant_id sequence 0 then 1.
REQ-047 Back-to-back contention: both channels request continuously for 6 accesses -> grants 0,1,0,1,0,1, with no overlap of mem strobes.
REQ-048 Timeout: TIMEOUT=4, mem_rdy tied to 0, ch1 read -> req_rdy[1] high 4 cycles after issue starts, req_rdata[15:8]=0, err_timeout=1 and staying 1.
REQ-049 Protocol error: ch0 oe=we=1 while ch1 issues a write -> err_proto=1, only ch1 is granted, req_rdy[0] stays 0.
REQ-050 Reset mid-access: reset asserted during ISSUE -> next cycle mem_oe=0, busy=0, req_rdy=0, err flags cleared; a later mem_rdy produces no req_rdy.
